// File: rtl/ps2_pkg.sv
// Shared constants, game key codes and frame-state type for the PS/2 receiver.
package ps2_pkg;

  localparam logic [7:0]  PS2_EXT   = 8'hE0;
  localparam logic [7:0]  PS2_BRK   = 8'hF0;

  localparam logic [15:0] KEY_UP    = 16'hE075;
  localparam logic [15:0] KEY_DOWN  = 16'hE072;
  localparam logic [15:0] KEY_LEFT  = 16'hE06B;
  localparam logic [15:0] KEY_RIGHT = 16'hE074;
  localparam logic [7:0]  KEY_A     = 8'h1C;
  localparam logic [7:0]  KEY_E     = 8'h24;
  localparam logic [7:0]  KEY_I     = 8'h43;
  localparam logic [7:0]  KEY_O     = 8'h44;
  localparam logic [7:0]  KEY_U     = 8'h3C;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: pin synchronisers, falling-edge detect and frame FSM.
// Optional stall watchdog enabled by defining PS2_WATCHDOG_EN.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int          SYNC_STAGES    = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_error
);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_dat_s;
  logic                   w_fall;
  logic                   w_timeout;

  frame_state_e r_state, w_state_nxt;
  logic [2:0]   r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]   r_shift, w_shift_nxt;
  logic         r_par, w_par_nxt;
  logic         r_byte_valid, w_byte_valid_nxt;
  logic         r_frame_error, w_frame_error_nxt;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = ~w_clk_s & r_clk_prev;

  // Synchronisers idle high, matching the released PS/2 bus.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync <= {SYNC_STAGES{1'b1}};
      r_dat_sync <= {SYNC_STAGES{1'b1}};
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_dat};
      r_clk_prev <= w_clk_s;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= 3'd0;
      r_shift       <= 8'h00;
      r_par         <= 1'b0;
      r_byte_valid  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_shift       <= w_shift_nxt;
      r_par         <= w_par_nxt;
      r_byte_valid  <= w_byte_valid_nxt;
      r_frame_error <= w_frame_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_shift_nxt       = r_shift;
    w_par_nxt         = r_par;
    w_byte_valid_nxt  = 1'b0;
    w_frame_error_nxt = 1'b0;
    if (w_timeout) begin
      w_state_nxt       = ST_IDLE;
      w_bit_cnt_nxt     = 3'd0;
      w_shift_nxt       = 8'h00;
      w_frame_error_nxt = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        ST_IDLE: begin
          // A high data bit on a fall is a glitch, not a start bit.
          if (!w_dat_s) begin
            w_state_nxt   = ST_DATA;
            w_bit_cnt_nxt = 3'd0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_DATA: begin
          w_shift_nxt   = {w_dat_s, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = ST_PARITY;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
        ST_PARITY: begin
          w_par_nxt   = w_dat_s;
          w_state_nxt = ST_STOP;
        end
        ST_STOP: begin
          w_state_nxt = ST_IDLE;
          if (w_dat_s && odd_parity_ok(r_shift, r_par)) begin
            w_byte_valid_nxt = 1'b1;
          end else begin
            w_frame_error_nxt = 1'b1;
            w_shift_nxt       = 8'h00;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

`ifdef PS2_WATCHDOG_EN
  logic [15:0] r_wd_cnt;

  // Counts clocks since the last fall while a frame is in progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd_cnt <= 16'd0;
    end else if ((r_state == ST_IDLE) || w_fall) begin
      r_wd_cnt <= 16'd0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end

  assign w_timeout = (r_state != ST_IDLE) && (r_wd_cnt == TIMEOUT_CYCLES);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  assign o_byte_valid  = r_byte_valid;
  assign o_byte        = r_shift;
  assign o_frame_error = r_frame_error;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver top: frame deserialiser plus make/break key decoder.
// Stall watchdog in the frame receiver is enabled by defining PS2_WATCHDOG_EN.
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int          SYNC_STAGES    = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ps2_clk,
  input  logic        i_ps2_dat,
  output logic        o_key_pressed,
  output logic [15:0] o_user_input,
  output logic        o_frame_error
);

  logic        w_byte_valid;
  logic [7:0]  w_byte;
  logic        w_frame_error;
  logic [15:0] w_code;

  logic        r_ext;
  logic        r_brk;
  logic        r_key_pressed;
  logic [15:0] r_user_input;

  ps2_frame_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_rx (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_ps2_clk     (i_ps2_clk),
    .i_ps2_dat     (i_ps2_dat),
    .o_byte_valid  (w_byte_valid),
    .o_byte        (w_byte),
    .o_frame_error (w_frame_error)
  );

  assign w_code = {(r_ext ? PS2_EXT : 8'h00), w_byte};

  // Make/break decoder; a rejected frame drops any pending prefix.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ext         <= 1'b0;
      r_brk         <= 1'b0;
      r_key_pressed <= 1'b0;
      r_user_input  <= 16'h0000;
    end else if (w_frame_error) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_byte_valid) begin
      if (w_byte == PS2_EXT) begin
        r_ext <= 1'b1;
      end else if (w_byte == PS2_BRK) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        if (!r_brk) begin
          r_user_input  <= w_code;
          r_key_pressed <= 1'b1;
        end else if (r_key_pressed && (w_code == r_user_input)) begin
          r_key_pressed <= 1'b0;
        end
      end
    end
  end

  assign o_key_pressed = r_key_pressed;
  assign o_user_input  = r_user_input;
  assign o_frame_error = w_frame_error;

endmodule

// File: doc/ps2_key_receiver.md
# ps2_key_receiver

- Upstream input stage of the game datapath: deserialises PS/2 keyboard frames into scan codes and tracks make/break sequences.
- Drives the `key_pressed` level and the 16-bit `user_input` key code consumed by the control FSM and the answer judge.
- Flags malformed frames so corrupted keystrokes never reach the judge.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth on `ps2_clk` and `ps2_dat` (min 2).
- `TIMEOUT_CYCLES`, default 16'd50000: idle-clock limit for an in-progress frame (used only with watchdog).
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_dat` in 1: raw PS/2 data pin, asynchronous.
- `key_pressed` out 1: high from make code of held key until its break code.
- `user_input` out 16: `{prefix, code}`; prefix 8'hE0 for extended keys, else 8'h00.
- `frame_error` out 1: one-cycle pulse on a rejected frame.

## Operation
- Both pins pass through `SYNC_STAGES` flops. One extra flop on synced clock detects the falling edge (`sync==0 && prev==1`). Data is sampled only on a detected fall.
- Frame FSM states and transitions:
  - IDLE: a fall with data 0 goes to DATA; a fall with data 1 is a glitch and stays in IDLE with no error.
  - DATA: shifts 8 bits LSB first. Bit counter 0..7; after bit 7 goes to PARITY.
  - PARITY: captures the parity bit, then goes to STOP.
  - STOP: stop=1 and odd parity over data+parity correct gives a one-cycle `byte_valid` with the byte. Otherwise `frame_error` pulses. Returns to IDLE in either case.
- Decoder, acting on each `byte_valid`:
  - 8'hE0 sets `ext`.
  - 8'hF0 sets `brk`.
  - Any other byte completes a code, after which `ext` and `brk` are cleared.
- Make (`brk=0`):
  - `user_input <= {ext?8'hE0:8'h00, byte}` and `key_pressed <= 1`.
  - Typematic repeat of the held code causes no visible change.
  - A make of a different key while one is held overwrites `user_input`; `key_pressed` stays 1.
- Break (`brk=1`):
  - If `{ext,byte}` matches the held `user_input`, `key_pressed <= 0`; `user_input` retains its value.
  - A break for a non-held key is ignored.
- On `frame_error`, `ext` and `brk` are cleared and the partial byte is discarded.
- Reset values: `key_pressed`=0, `user_input`=16'h0000, `frame_error`=0. Frame FSM is IDLE, `ext`/`brk`=0, synchronisers are 1 (bus idle).
- Reset asserted mid-frame aborts immediately. The first fall after release is treated as a start-bit candidate.

## Timing
- The ps2_clk falling edge is visible internally `SYNC_STAGES`+1 clk edges after it is first sampled.
- `byte_valid` asserts one cycle after the stop-bit fall is detected.
- `key_pressed` and `user_input` update on the next edge, i.e. `SYNC_STAGES`+2 clk edges after the stop-bit fall is first sampled.
- `frame_error` asserts at the same point as `byte_valid` would and lasts exactly one cycle.
- Back-to-back frames need no gap; the FSM accepts a start bit on the first fall after STOP.

## Configuration
- `PS2_WATCHDOG_EN` defined:
  - A 16-bit counter runs while the frame FSM is not in IDLE and resets on every detected fall.
  - Reaching `TIMEOUT_CYCLES` forces IDLE, pulses `frame_error` and clears `ext`/`brk`.
- `PS2_WATCHDOG_EN` undefined: no counter exists. A stalled frame waits indefinitely, and `TIMEOUT_CYCLES` is unused.

## Structure
- Package `ps2_pkg` holds:
  - `PS2_EXT`=8'hE0 and `PS2_BRK`=8'hF0.
  - Game key codes: UP 16'hE075, DOWN 16'hE072, LEFT 16'hE06B, RIGHT 16'hE074; A 8'h1C, E 8'h24, I 8'h43, O 8'h44, U 8'h3C.
  - The frame-state enum.
- One sub-module, `ps2_frame_rx`: synchroniser, edge detect, frame FSM and watchdog. Outputs `byte_valid`, `byte` and `frame_error`.
- The top level holds the make/break decoder.

## Test plan
- Reset, then send frame 8'h1C (parity 0, stop 1): `key_pressed`=1 and `user_input`=16'h001C at the specified latency; `frame_error` stays 0.
- Continue with F0,1C: `key_pressed` falls to 0 after the 1C frame; `user_input` remains 16'h001C.
- Send E0,75 then E0,F0,75: `user_input`=16'hE075 with `key_pressed`=1, then `key_pressed`=0.
- Send 8'h1C with parity bit 1: single-cycle `frame_error`; outputs unchanged. A following clean 8'h24 frame yields `user_input`=16'h0024.
- Hold 1C, then send F0,24: `key_pressed` stays 1 and `user_input` stays 16'h001C. Repeat 1C: no change.
- With `PS2_WATCHDOG_EN` defined: send start plus 3 bits, then idle `TIMEOUT_CYCLES` cycles: `frame_error` pulses once. A subsequent clean 8'h43 frame decodes to 16'h0043. Assert `rst_n` mid-frame: all outputs go to 0 immediately.
